// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard/forwarding controller
// Contents:
//   MAX_REG_W   widest register address the scoreboard can store (REG_W is zero-extended into it)
//   SEL_REGFILE forwarding select value meaning "read the register file"
//   sb_entry_t  one scoreboard entry {valid, is_load, wr_reg}
//   sel_width   width of a forwarding select for n tracked stages
package hazard_pkg;

    localparam int MAX_REG_W   = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic                 is_load;
        logic [MAX_REG_W-1:0] wr_reg;
    } sb_entry_t;

    function automatic int sel_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// rtl/hazard_fwd_match.sv - priority match of one source operand against the in-flight scoreboard
// Ports:
//   sb           scoreboard, index 1 = execute (youngest) .. NUM_FWD_STAGES = writeback (oldest)
//   src          source register address
//   uses         operand is actually read
//   sel          0 = register file, k = forward from stage k
//   load_hazard  winning producer is a load whose data is not yet available
import hazard_pkg::*;

module hazard_fwd_match #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter int REG_W          = 5,
    parameter int SEL_W          = sel_width(NUM_FWD_STAGES)
) (
    input  sb_entry_t        sb [1:NUM_FWD_STAGES],
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    output logic [SEL_W-1:0] sel,
    output logic             load_hazard
);

    logic [MAX_REG_W-1:0] src_ext;

    assign src_ext = MAX_REG_W'(src);

    // Walk oldest to youngest so the youngest match overwrites older ones.
    // $0 is hardwired to zero and never forwarded.
    always_comb begin
        sel         = SEL_W'(SEL_REGFILE);
        load_hazard = 1'b0;
        for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            if (uses && (src != '0) && sb[k].valid && (sb[k].wr_reg == src_ext)) begin
                sel         = SEL_W'(k);
                load_hazard = sb[k].is_load && (k <= LOAD_LATENCY);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard-based hazard, stall, forwarding and redirect controller
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall_in                   external freeze, whole pipeline holds
//   dec_*                      decode-stage instruction description
//   redirect                   taken branch/jump pulse from stage 1
//   fwd_sel_a, fwd_sel_b       per-operand forwarding selects (0 = register file)
//   stall                      hold PC and decode register
//   bubble                     NOP injected into stage 1 this cycle
//   flush                      kill fetched instruction, PC takes redirect target
//   stall_cycles               saturating count of stalled cycles
import hazard_pkg::*;

module pipe_hazard_ctrl #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter bit DELAY_SLOT     = 1'b1,
    parameter int REG_W          = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  stall_in,
    input  logic                                  dec_valid,
    input  logic [REG_W-1:0]                      dec_rs,
    input  logic [REG_W-1:0]                      dec_rt,
    input  logic                                  dec_uses_rs,
    input  logic                                  dec_uses_rt,
    input  logic                                  dec_wr_en,
    input  logic [REG_W-1:0]                      dec_wr_reg,
    input  logic                                  dec_is_load,
    input  logic                                  redirect,
    output logic [sel_width(NUM_FWD_STAGES)-1:0]  fwd_sel_a,
    output logic [sel_width(NUM_FWD_STAGES)-1:0]  fwd_sel_b,
    output logic                                  stall,
    output logic                                  bubble,
    output logic                                  flush,
    output logic [31:0]                           stall_cycles
);

    localparam int SEL_W = sel_width(NUM_FWD_STAGES);

    sb_entry_t sb [1:NUM_FWD_STAGES];
    sb_entry_t issue_entry;
    logic      pending;
    logic      haz_a, haz_b;
    logic      hazard, hazard_eff;
    logic      redir_req, kill, issue;

    hazard_fwd_match #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .LOAD_LATENCY   (LOAD_LATENCY),
        .REG_W          (REG_W),
        .SEL_W          (SEL_W)
    ) u_match_rs (
        .sb          (sb),
        .src         (dec_rs),
        .uses        (dec_uses_rs),
        .sel         (fwd_sel_a),
        .load_hazard (haz_a)
    );

    hazard_fwd_match #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .LOAD_LATENCY   (LOAD_LATENCY),
        .REG_W          (REG_W),
        .SEL_W          (SEL_W)
    ) u_match_rt (
        .sb          (sb),
        .src         (dec_rt),
        .uses        (dec_uses_rt),
        .sel         (fwd_sel_b),
        .load_hazard (haz_b)
    );

    // A redirect arriving while one is already pending is ignored; the
    // pending one keeps requesting a flush until a non-stalled cycle.
    assign redir_req  = redirect | pending;
    assign hazard     = dec_valid & (haz_a | haz_b);
    // Without a delay slot the decode instruction dies anyway, so its
    // load-use hazard is irrelevant and the flush goes out at once.
    assign hazard_eff = hazard & ~(~DELAY_SLOT & redir_req);
    assign stall      = stall_in | hazard_eff;
    assign flush      = redir_req & ~stall;
    assign kill       = flush & ~DELAY_SLOT;
    assign issue      = ~stall_in & dec_valid & ~hazard_eff & ~kill;
    assign bubble     = ~stall_in & dec_valid & ~issue;

    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = issue & dec_wr_en;
        issue_entry.is_load = dec_is_load;
        issue_entry.wr_reg  = MAX_REG_W'(dec_wr_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
                sb[k] <= '0;
            end
            pending      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!stall_in) begin
                for (int k = NUM_FWD_STAGES; k >= 2; k--) begin
                    sb[k] <= sb[k-1];
                end
                sb[1] <= issue_entry;
            end
            pending <= flush ? 1'b0 : redir_req;
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall_in, dec_valid, dec_uses_rs, dec_uses_rt;
    logic        dec_wr_en, dec_is_load, redirect;
    logic [4:0]  dec_rs, dec_rt, dec_wr_reg;

    // u0: N=2 LL=1 DS=1, u1: N=3 LL=2 DS=1, u2: N=2 LL=1 DS=0
    logic [1:0]  sel_a0, sel_b0, sel_a1, sel_b1, sel_a2, sel_b2;
    logic        stall0, bubble0, flush0, stall1, bubble1, flush1, stall2, bubble2, flush2;
    logic [31:0] sc0, sc1, sc2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NUM_FWD_STAGES(2), .LOAD_LATENCY(1), .DELAY_SLOT(1'b1), .REG_W(5)) u0 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_wr_en(dec_wr_en), .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load),
        .redirect(redirect), .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0), .stall(stall0),
        .bubble(bubble0), .flush(flush0), .stall_cycles(sc0));

    pipe_hazard_ctrl #(.NUM_FWD_STAGES(3), .LOAD_LATENCY(2), .DELAY_SLOT(1'b1), .REG_W(5)) u1 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_wr_en(dec_wr_en), .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load),
        .redirect(redirect), .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1), .stall(stall1),
        .bubble(bubble1), .flush(flush1), .stall_cycles(sc1));

    pipe_hazard_ctrl #(.NUM_FWD_STAGES(2), .LOAD_LATENCY(1), .DELAY_SLOT(1'b0), .REG_W(5)) u2 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_wr_en(dec_wr_en), .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load),
        .redirect(redirect), .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2), .stall(stall2),
        .bubble(bubble2), .flush(flush2), .stall_cycles(sc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        stall_in = 0; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_uses_rs = 0; dec_uses_rt = 0;
        dec_wr_en = 0; dec_wr_reg = 0; dec_is_load = 0; redirect = 0;
    endtask

    task automatic dec(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic wen, input logic [4:0] wreg, input logic ld);
        dec_valid = 1; dec_rs = rs; dec_uses_rs = urs; dec_rt = rt; dec_uses_rt = urt;
        dec_wr_en = wen; dec_wr_reg = wreg; dec_is_load = ld;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        tick();
        reset = 0;
    endtask

    initial begin
        do_reset();

        // Reset state
        settle();
        chk("rst_sel_a", 32'(sel_a0), 0);
        chk("rst_sel_b", 32'(sel_b0), 0);
        chk("rst_stall", 32'(stall0), 0);
        chk("rst_bubble", 32'(bubble0), 0);
        chk("rst_flush", 32'(flush0), 0);
        chk("rst_cnt", sc0, 0);

        // ALU forwarding: ADDU $3, then readers of $3 as it ages
        dec(5'd1, 1, 5'd2, 1, 1, 5'd3, 0);
        settle();
        chk("alu_issue_stall", 32'(stall0), 0);
        tick();
        dec(5'd3, 1, 5'd0, 0, 0, 5'd0, 0);
        settle();
        chk("alu_s1_sel_a", 32'(sel_a0), 1);
        chk("alu_s1_stall", 32'(stall0), 0);
        chk("alu_s1_sel_a_n3", 32'(sel_a1), 1);
        tick();
        settle();
        chk("alu_s2_sel_a", 32'(sel_a0), 2);
        chk("alu_s2_sel_a_n3", 32'(sel_a1), 2);
        tick();
        settle();
        chk("alu_retired_sel_a", 32'(sel_a0), 0);
        chk("alu_s3_sel_a_n3", 32'(sel_a1), 3);

        // Youngest writer wins; $0 never forwards
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd0, 0);
        tick();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd5, 0);
        tick();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd5, 0);
        tick();
        dec(5'd0, 1, 5'd5, 1, 0, 5'd0, 0);
        settle();
        chk("young_sel_b", 32'(sel_b0), 1);
        chk("young_sel_b_n3", 32'(sel_b1), 1);
        chk("zero_reg_sel_a_n3", 32'(sel_a1), 0);

        // Load-use: LW $4 then ADDU reading $4
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd4, 1);
        settle();
        chk("lw_issue_stall", 32'(stall0), 0);
        tick();
        dec(5'd4, 1, 5'd0, 0, 1, 5'd6, 0);
        settle();
        chk("lu_c1_stall", 32'(stall0), 1);
        chk("lu_c1_bubble", 32'(bubble0), 1);
        chk("lu_c1_stall_n3", 32'(stall1), 1);
        chk("lu_c1_bubble_n3", 32'(bubble1), 1);
        tick();
        settle();
        chk("lu_c2_sel_a", 32'(sel_a0), 2);
        chk("lu_c2_stall", 32'(stall0), 0);
        chk("lu_c2_bubble", 32'(bubble0), 0);
        chk("lu_c2_stall_n3", 32'(stall1), 1);
        tick();
        settle();
        chk("lu_c3_sel_a_n3", 32'(sel_a1), 3);
        chk("lu_c3_stall_n3", 32'(stall1), 0);
        chk("lu_cnt", sc0, 1);
        chk("lu_cnt_n3", sc1, 2);

        // External freeze with a writer in stage 1
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
        tick();
        dec(5'd7, 1, 5'd0, 0, 0, 5'd0, 0);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("frz_sel_a", 32'(sel_a0), 1);
            chk("frz_stall", 32'(stall0), 1);
            chk("frz_bubble", 32'(bubble0), 0);
            tick();
        end
        stall_in = 0;
        settle();
        chk("frz_after_sel_a", 32'(sel_a0), 1);
        chk("frz_after_stall", 32'(stall0), 0);
        chk("frz_cnt", sc0, 3);

        // Redirect during a load-use stall
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd4, 1);
        tick();
        dec(5'd4, 1, 5'd0, 0, 1, 5'd6, 0);
        redirect = 1;
        settle();
        chk("rd_c1_flush_ds1", 32'(flush0), 0);
        chk("rd_c1_stall_ds1", 32'(stall0), 1);
        chk("rd_c1_flush_ds0", 32'(flush2), 1);
        chk("rd_c1_bubble_ds0", 32'(bubble2), 1);
        chk("rd_c1_stall_ds0", 32'(stall2), 0);
        tick();
        redirect = 0;
        settle();
        chk("rd_c2_flush_ds1", 32'(flush0), 1);
        chk("rd_c2_bubble_ds1", 32'(bubble0), 0);
        chk("rd_c2_flush_ds0", 32'(flush2), 0);
        chk("rd_c2_flush_n3", 32'(flush1), 0);
        tick();
        settle();
        chk("rd_c3_flush_ds1", 32'(flush0), 0);
        chk("rd_c3_flush_n3", 32'(flush1), 1);
        tick();
        settle();
        chk("rd_c4_flush_n3", 32'(flush1), 0);

        // Redirect under external freeze is held until release
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        stall_in = 1;
        redirect = 1;
        settle();
        chk("rdf_c1_flush", 32'(flush0), 0);
        tick();
        redirect = 0;
        settle();
        chk("rdf_c2_flush", 32'(flush0), 0);
        tick();
        stall_in = 0;
        settle();
        chk("rdf_c3_flush", 32'(flush0), 1);
        chk("rdf_c3_bubble_ds1", 32'(bubble0), 0);
        chk("rdf_c3_bubble_ds0", 32'(bubble2), 1);
        tick();
        settle();
        chk("rdf_c4_flush", 32'(flush0), 0);

        // Reset with a full scoreboard and a pending redirect
        do_reset();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd1, 0);
        tick();
        dec(5'd0, 0, 5'd0, 0, 1, 5'd2, 0);
        tick();
        dec(5'd2, 1, 5'd0, 0, 0, 5'd0, 0);
        stall_in = 1;
        redirect = 1;
        settle();
        chk("pre_rst_sel_a", 32'(sel_a0), 1);
        tick();
        redirect = 0;
        reset = 1;
        tick();
        reset = 0;
        stall_in = 0;
        dec_valid = 0;
        settle();
        chk("post_rst_sel_a", 32'(sel_a0), 0);
        chk("post_rst_stall", 32'(stall0), 0);
        chk("post_rst_bubble", 32'(bubble0), 0);
        chk("post_rst_flush", 32'(flush0), 0);
        chk("post_rst_cnt", sc0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the MIPS150 pipeline. It replaces the fixed one-stage-back forwarding compare in the control decoder with a scoreboard of in-flight destination registers across `NUM_FWD_STAGES` stages. It produces per-operand forwarding selects, load-use stalls, external-stall freeze, and branch/jump flush, with an optional delay slot and a redirect that is held through stalls. It sits between decode and the execute-stage operand muxes.

## Interface
- `NUM_FWD_STAGES`, 2: in-flight stages tracked after decode (stage 1 = execute … stage N = writeback), range 1–7.
- `LOAD_LATENCY`, 1: a load result is forwardable once the load reaches stage `LOAD_LATENCY+1`, range 0 to N-1.
- `DELAY_SLOT`, 1: 1 means the decode instruction survives a redirect (MIPS delay slot); 0 means it is killed.
- `REG_W`, 5: register address width.
- `clk`  in  1  clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `stall_in`  in  1  external freeze (UART/memory busy); the whole pipeline holds.
- `dec_valid`  in  1  decode holds a real instruction.
- `dec_rs`, `dec_rt`  in  REG_W  source registers.
- `dec_uses_rs`, `dec_uses_rt`  in  1  source actually read.
- `dec_wr_en`  in  1  instruction writes a register.
- `dec_wr_reg`  in  REG_W  destination (rd, rt, or 31 for JAL, resolved upstream).
- `dec_is_load`  in  1  LB/LH/LW/LBU/LHU.
- `redirect`  in  1  one-cycle pulse when the branch/jump in stage 1 is taken.
- `fwd_sel_a`, `fwd_sel_b`  out  SEL_W=$clog2(N+1)  0 = register file, k = stage k result.
- `stall`  out  1  hold PC and the decode register.
- `bubble`  out  1  NOP injected into stage 1 this cycle.
- `flush`  out  1  kill the fetched instruction; PC takes the redirect target.
- `stall_cycles`  out  32  saturating count of cycles with `stall`=1.

## Operation
- Scoreboard: N entries {valid, wr_reg, is_load}. An entry matches register r when valid, wr_reg==r, and r!=0.
- Operand select: the youngest (lowest k) matching stage wins; no match gives 0. Operands not used give select 0.
- Load-use hazard: the winning match is a load with k ≤ LOAD_LATENCY, and `dec_valid` is set.
- `stall` = `stall_in` | hazard | (redirect_pending & `stall_in`).
- Advance when `stall_in`=0: entries shift k→k+1 and entry N retires.
  - Stage 1 takes the decode instruction when `dec_valid`, no hazard, and it is not killed.
  - Otherwise stage 1 takes an invalid entry and `bubble`=1.
- `stall_in`=1: nothing shifts, `bubble`=0, and the selects still reflect the current state.
- Redirect:
  - If `redirect` arrives while `stall`=0: `flush`=1 that cycle.
  - If `redirect` arrives while `stall`=1: set redirect_pending. `flush` is raised on the first cycle with `stall`=0, then pending clears.
  - With `DELAY_SLOT`=0, the decode instruction is killed (bubble) in the flush cycle.
  - A second `redirect` while pending is a protocol error and is ignored.
- Redirect and hazard together:
  - With `DELAY_SLOT`=1, the hazard stall runs first and `flush` fires when the delay-slot instruction issues.
  - With `DELAY_SLOT`=0, `flush` wins immediately and the hazard is dropped.
- `stall_cycles` increments on each `stall`=1 cycle and saturates at 2^32-1.

## Timing
- Selects, `stall`, `bubble`, and `flush` are combinational from scoreboard state plus decode inputs, with no added latency.
- The scoreboard and pending flag update on posedge `clk`.
- Load-use stall length is LOAD_LATENCY−k+1 cycles (1 cycle for the defaults with the load in stage 1).
- The register file is write-first, so a writer retired past stage N is read via select 0.
- Reset: all entries invalid, pending=0, counter=0. All outputs are then 0.
- Reset mid-stall or mid-pending clears everything on the next edge.

## Structure
- Package `hazard_pkg`:
  - `sb_entry_t` struct.
  - `SEL_REGFILE`=0.
  - function `sel_width(n)`.
- Sub-module `hazard_fwd_match`: priority encoder over the scoreboard for one operand, returning {sel, load_hazard}. Instantiated for rs and rt.

## Test plan
- ADDU $3 in stage 1 with decode reading rs=$3 → `fwd_sel_a`=1, `stall`=0.
  - Same with N=3 and the writer in stage 3 → `fwd_sel_a`=3.
- $5 written in both stage 1 and stage 2, decode reads rt=$5 → `fwd_sel_b`=1 (youngest). Writes to $0 → select 0.
- LW $4 in stage 1, decode ADDU reads $4 (LOAD_LATENCY=1):
  - 1 cycle `stall`=1, `bubble`=1.
  - Next cycle `fwd_sel`=2 and the instruction issues.
  - With LOAD_LATENCY=2: 2 stall cycles, then select 3.
- `stall_in` held 3 cycles with a pending writer in stage 1 → scoreboard frozen, `fwd_sel` constant, `stall_cycles` +3.
- `redirect` during a load-use stall with DELAY_SLOT=1 → `flush` asserted exactly once, in the cycle the delay-slot instruction issues.
  - With DELAY_SLOT=0 → immediate `flush`+`bubble`.
- `reset` asserted with pending=1 and a full scoreboard → next cycle all outputs 0 and counter 0.
